// File: rtl/mbist_march_ctrl.sv
// March C- BIST engine for a single-port word memory with first-fail capture.
// Optional MBIST_DIAG_EN: run through all elements after mismatches and count them in fail_cnt.
module mbist_march_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned LAST_ADDR  = 2**ADDR_WIDTH - 1,
  parameter int unsigned RD_LAT     = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic                  mem_write_read,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [2:0]            fail_element,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic [7:0]            fail_cnt
);

  localparam int unsigned DRW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic                  valid;
    logic [DATA_WIDTH-1:0] exp;
    logic [ADDR_WIDTH-1:0] addr;
    logic [2:0]            elem;
  } cmp_t;

  state_t                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic                  op_q, op_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [DRW-1:0]        drain_q, drain_d;
  logic                  busy_d, done_d, pass_d, wr_d;
  logic [DATA_WIDTH-1:0] wdata_d, fail_data_d;
  logic [ADDR_WIDTH-1:0] fail_addr_d;
  logic [2:0]            fail_elem_d;
  logic [7:0]            fail_cnt_d;
  cmp_t [RD_LAT-1:0]     pipe_q, pipe_d;
  cmp_t                  tail_c;
  logic                  mismatch_c, at_end_c;

  // Elements 3 and 4 walk the address space downward.
  function automatic logic elem_desc(input logic [2:0] e);
    return (e == 3'd3) || (e == 3'd4);
  endfunction

  function automatic logic elem_two_op(input logic [2:0] e);
    return (e != 3'd0) && (e != 3'd5);
  endfunction

  function automatic logic op_write(input logic [2:0] e, input logic o);
    return (e == 3'd0) || (elem_two_op(e) && o);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] wr_data(input logic [2:0] e);
    return ((e == 3'd1) || (e == 3'd3)) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] rd_exp(input logic [2:0] e);
    return ((e == 3'd2) || (e == 3'd4)) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
  endfunction

  always_comb begin
    state_d     = state_q;
    elem_d      = elem_q;
    op_d        = op_q;
    addr_d      = mem_address;
    drain_d     = drain_q;
    busy_d      = busy;
    done_d      = done;
    pass_d      = pass;
    wr_d        = 1'b0;
    wdata_d     = mem_wdata;
    fail_addr_d = fail_addr;
    fail_elem_d = fail_element;
    fail_data_d = fail_data;
    fail_cnt_d  = fail_cnt;
    at_end_c    = 1'b0;
    tail_c      = pipe_q[RD_LAT-1];
    mismatch_c  = ((state_q == S_RUN) || (state_q == S_DRAIN)) && tail_c.valid &&
                  (mem_rdata != tail_c.exp);

    // Head of the compare pipe describes the read on the bus this cycle.
    pipe_d[0].valid = (state_q == S_RUN) && !mem_write_read;
    pipe_d[0].exp   = rd_exp(elem_q);
    pipe_d[0].addr  = mem_address;
    pipe_d[0].elem  = elem_q;
    for (int i = 1; i < int'(RD_LAT); i++) pipe_d[i] = pipe_q[i-1];

    if (mismatch_c && pass) begin
      pass_d      = 1'b0;
      fail_addr_d = tail_c.addr;
      fail_elem_d = tail_c.elem;
      fail_data_d = mem_rdata;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d     = S_PREP;
          busy_d      = 1'b1;
          done_d      = 1'b0;
          pass_d      = 1'b1;
          fail_addr_d = '0;
          fail_elem_d = '0;
          fail_data_d = '0;
          fail_cnt_d  = '0;
          elem_d      = '0;
          op_d        = 1'b0;
          addr_d      = '0;
          drain_d     = '0;
          for (int i = 0; i < int'(RD_LAT); i++) pipe_d[i] = '0;
        end
      end
      S_PREP: state_d = S_RUN;
      S_RUN: begin
        at_end_c = elem_desc(elem_q) ? (mem_address == '0)
                                     : (mem_address == ADDR_WIDTH'(LAST_ADDR));
        if (elem_two_op(elem_q) && !op_q) begin
          op_d = 1'b1;
        end else begin
          op_d = 1'b0;
          if (!at_end_c) begin
            addr_d = elem_desc(elem_q) ? mem_address - ADDR_WIDTH'(1)
                                       : mem_address + ADDR_WIDTH'(1);
          end else if (elem_q == 3'd5) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end else begin
            elem_d = elem_q + 3'd1;
            addr_d = elem_desc(elem_q + 3'd1) ? ADDR_WIDTH'(LAST_ADDR) : '0;
          end
        end
      end
      S_DRAIN: begin
        if (drain_q == DRW'(RD_LAT - 1)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          drain_d = drain_q + DRW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

`ifdef MBIST_DIAG_EN
    if (mismatch_c && (fail_cnt != 8'hFF)) fail_cnt_d = fail_cnt + 8'd1;
`else
    if (mismatch_c) begin
      state_d = S_DONE;
      busy_d  = 1'b0;
      done_d  = 1'b1;
    end
`endif

    // Write data leads by one cycle; a write always follows an op of its own element (or PREP).
    wr_d    = (state_d == S_RUN) && op_write(elem_d, op_d);
    wdata_d = wr_data(elem_d);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      elem_q         <= '0;
      op_q           <= 1'b0;
      drain_q        <= '0;
      pipe_q         <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      mem_write_read <= 1'b0;
      mem_address    <= '0;
      mem_wdata      <= '0;
      fail_addr      <= '0;
      fail_element   <= '0;
      fail_data      <= '0;
      fail_cnt       <= '0;
    end else begin
      state_q        <= state_d;
      elem_q         <= elem_d;
      op_q           <= op_d;
      drain_q        <= drain_d;
      pipe_q         <= pipe_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      mem_write_read <= wr_d;
      mem_address    <= addr_d;
      mem_wdata      <= wdata_d;
      fail_addr      <= fail_addr_d;
      fail_element   <= fail_elem_d;
      fail_data      <= fail_data_d;
      fail_cnt       <= fail_cnt_d;
    end
  end

endmodule
